// File: rtl/hdu_scoreboard.sv
// hdu_scoreboard: ID-stage hazard detection unit built around a per-register
// countdown scoreboard. Each nonzero counter marks a result still in flight;
// its value is the number of cycles before a dependent instruction may issue.
// Stalls cover RAW dependences and WAW re-issue that could retire out of
// order. The unit also gates the branch-taken decision and keeps a saturating
// stall counter for performance monitoring.
module hdu_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = 3,
    parameter int PCNT_W   = 16
) (
    input  logic              Clk_in,
    input  logic              Rst_n_in,
    input  logic              Valid_ID_in,
    input  logic              Flush_ID_in,
    input  logic              Branch_ID_in,
    input  logic              Zr_in,
    input  logic [ADDR_W-1:0] RS1Addr_ID_in,
    input  logic [ADDR_W-1:0] RS2Addr_ID_in,
    input  logic              UseRS1_ID_in,
    input  logic              UseRS2_ID_in,
    input  logic              RegWrite_ID_in,
    input  logic [ADDR_W-1:0] RDAddr_ID_in,
    input  logic [LAT_W-1:0]  Lat_ID_in,
    output logic              Stall_out,
    output logic              Taken_out,
    output logic              Busy_out,
    output logic [PCNT_W-1:0] StallCnt_out
);

    localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(MAX_LAT);
    localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_TOP = '1;

    // Latency 0 would mean "result already available" and would never set a
    // counter; treat it as an ALU op. Anything beyond MAX_LAT is clipped so
    // the counter range stays bounded.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        logic [LAT_W-1:0] res;
        if (lat == '0) begin
            res = LAT_ONE;
        end else if (lat > LAT_MAX) begin
            res = LAT_MAX;
        end else begin
            res = lat;
        end
        return res;
    endfunction

    // Saturating increment for the performance counter: never wraps.
    function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] val);
        logic [PCNT_W-1:0] res;
        if (val == PCNT_TOP) begin
            res = val;
        end else begin
            res = val + PCNT_ONE;
        end
        return res;
    endfunction

    // Storage exists only for r >= 1; x0 reads as a constant zero through
    // cnt_view so it can never produce a hazard.
    logic [LAT_W-1:0]  cnt_q    [1:NUM_REGS-1];
    logic [LAT_W-1:0]  cnt_view [NUM_REGS];
    logic [PCNT_W-1:0] stall_cnt_q;

    logic [LAT_W-1:0] eff_lat;
    logic [LAT_W-1:0] lat_m1;
    logic             live;
    logic             raw_rs1;
    logic             raw_rs2;
    logic             raw;
    logic             waw;
    logic             stall;
    logic             issue;
    logic             any_busy;

    // Expose the counters as a full NUM_REGS-entry table with entry 0 tied off.
    always_comb begin
        cnt_view[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_view[r] = cnt_q[r];
        end
    end

    // Hazard evaluation: purely combinational from the current counters.
    always_comb begin
        eff_lat = clamp_lat(Lat_ID_in);
        lat_m1  = eff_lat - LAT_ONE;
        live    = Valid_ID_in & ~Flush_ID_in;

        raw_rs1 = UseRS1_ID_in & (RS1Addr_ID_in != '0)
                & (cnt_view[RS1Addr_ID_in] != '0);
        raw_rs2 = UseRS2_ID_in & (RS2Addr_ID_in != '0)
                & (cnt_view[RS2Addr_ID_in] != '0);
        raw     = raw_rs1 | raw_rs2;

        // A new write may only go ahead if it cannot complete before (or at
        // the same time as) an older in-flight write to the same register.
        waw     = RegWrite_ID_in & (RDAddr_ID_in != '0)
                & (cnt_view[RDAddr_ID_in] > lat_m1);

        stall   = live & (raw | waw);
        issue   = live & ~stall & RegWrite_ID_in & (RDAddr_ID_in != '0);
    end

    // Busy when any in-flight result is still counting down.
    always_comb begin
        any_busy = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            any_busy = any_busy | (cnt_q[r] != '0);
        end
    end

    // Scoreboard update: a new issue reloads its entry, otherwise count down.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue && (RDAddr_ID_in == ADDR_W'(r))) begin
                    cnt_q[r] <= lat_m1;
                end else if (cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - LAT_ONE;
                end
            end
        end
    end

    // Performance monitor: count stalled cycles, holding at all-ones.
    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign Stall_out    = stall;
    assign Taken_out    = live & Branch_ID_in & Zr_in & ~stall;
    assign Busy_out     = any_busy;
    assign StallCnt_out = stall_cnt_q;

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Self-checking bench for hdu_scoreboard. The reference model tracks, per
// register, the cycle number at which its pending result becomes readable,
// and derives stalls, branch gating and busy from that timeline.
module tb_hdu_scoreboard;

    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int MAXL   = 4;
    localparam int LAT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              valid;
    logic              flush;
    logic              branch;
    logic              zr;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              use1;
    logic              use2;
    logic              regwrite;
    logic [ADDR_W-1:0] rd;
    logic [LAT_W-1:0]  lat;

    logic              stall_a, taken_a, busy_a;
    logic [15:0]       scnt_a;
    logic              stall_b, taken_b, busy_b;
    logic [3:0]        scnt_b;

    hdu_scoreboard #(.PCNT_W(16)) dut (
        .Clk_in(clk), .Rst_n_in(rst_n), .Valid_ID_in(valid), .Flush_ID_in(flush),
        .Branch_ID_in(branch), .Zr_in(zr), .RS1Addr_ID_in(rs1), .RS2Addr_ID_in(rs2),
        .UseRS1_ID_in(use1), .UseRS2_ID_in(use2), .RegWrite_ID_in(regwrite),
        .RDAddr_ID_in(rd), .Lat_ID_in(lat), .Stall_out(stall_a), .Taken_out(taken_a),
        .Busy_out(busy_a), .StallCnt_out(scnt_a)
    );

    hdu_scoreboard #(.PCNT_W(4)) dut_sat (
        .Clk_in(clk), .Rst_n_in(rst_n), .Valid_ID_in(valid), .Flush_ID_in(flush),
        .Branch_ID_in(branch), .Zr_in(zr), .RS1Addr_ID_in(rs1), .RS2Addr_ID_in(rs2),
        .UseRS1_ID_in(use1), .UseRS2_ID_in(use2), .RegWrite_ID_in(regwrite),
        .RDAddr_ID_in(rd), .Lat_ID_in(lat), .Stall_out(stall_b), .Taken_out(taken_b),
        .Busy_out(busy_b), .StallCnt_out(scnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: cycle index and per-register "readable from" cycle.
    int now = 0;
    int avail [NREG];
    int pcnt16 = 0;
    int pcnt4  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) avail[r] = 0;
        pcnt16 = 0;
        pcnt4  = 0;
    endtask

    function automatic bit model_busy();
        bit b = 0;
        for (int r = 1; r < NREG; r++) if (avail[r] > now) b = 1;
        return b;
    endfunction

    // One ID cycle: drive, compare against the timeline model, clock, update.
    task automatic step(input bit v, input bit fl, input bit br, input bit z,
                        input int a1, input bit u1, input int a2, input bit u2,
                        input bit rw, input int d, input int l);
        int  eff;
        bit  live, raw, waw, st, tk;
        valid = v; flush = fl; branch = br; zr = z;
        rs1 = ADDR_W'(a1); use1 = u1; rs2 = ADDR_W'(a2); use2 = u2;
        regwrite = rw; rd = ADDR_W'(d); lat = LAT_W'(l);
        #2;
        eff  = (l == 0) ? 1 : ((l > MAXL) ? MAXL : l);
        live = v && !fl;
        raw  = (u1 && a1 != 0 && avail[a1] > now) || (u2 && a2 != 0 && avail[a2] > now);
        // New write would finish at now+eff; it must finish strictly after the old one.
        waw  = rw && d != 0 && avail[d] >= now + eff;
        st   = live && (raw || waw);
        tk   = live && br && z && !st;
        chk("stall",     stall_a, st);
        chk("taken",     taken_a, tk);
        chk("busy",      busy_a,  model_busy());
        chk("stallcnt",  scnt_a,  pcnt16);
        chk("stallcnt4", scnt_b,  pcnt4);
        @(posedge clk);
        if (live && !st && rw && d != 0) avail[d] = now + eff;
        if (st) begin
            if (pcnt16 < 65535) pcnt16++;
            if (pcnt4 < 15) pcnt4++;
        end
        now++;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        valid = 0; flush = 0; branch = 0; zr = 0; rs1 = '0; rs2 = '0;
        use1 = 0; use2 = 0; regwrite = 0; rd = '0; lat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall_a, 0);
        chk("rst_busy",  busy_a,  0);
        chk("rst_cnt",   scnt_a,  0);
        rst_n = 1'b1;
        now = 0;

        // Load then use: one stall cycle.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 2);
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1);
        chk("lu_stallcnt", scnt_a, 1);

        // ALU result is forwarded; unused RS2 never stalls.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1);
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 2);
        step(1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1);
        idle();

        // Long op: three stall cycles on RS2.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 4);
        repeat (4) step(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 1);
        // WAW re-issue of a short op behind a long op.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 4);
        repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1);
        repeat (2) idle();
        // x0 is never tracked.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4);
        step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);

        // Branch gating and squash.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 2);
        step(1, 0, 1, 1, 6, 1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 1, 6, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 2);
        step(1, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1);
        idle();

        // Asynchronous reset in the middle of a stall with cnt[3] = 2.
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3);
        valid = 1; flush = 0; branch = 1; zr = 1; rs1 = 5'd3; use1 = 1;
        use2 = 0; regwrite = 0; lat = 3'd1;
        #2;
        chk("pre_rst_stall", stall_a, 1);
        chk("pre_rst_busy",  busy_a,  1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall_a, 0);
        chk("arst_busy",  busy_a,  0);
        chk("arst_taken", taken_a, 1);
        chk("arst_cnt",   scnt_a,  0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        now++;
        step(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1);

        // Randomized traffic over a small register window for frequent hazards.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rnd_arst_busy", busy_a, 0);
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                now++;
            end
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 7));
        end
        chk("sat4_hold", scnt_b, pcnt4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
